bus_arbiter_rr: RTL and testbench

- N-master to 1-slave arbiter for the req/we/addr/be/wdata/ack/resp/rdata peripheral bus.
- Lets several masters (core data ports, debug/DMA port) share one slave, e.g. the GPIO slave or a slave-side address decoder.
- Grants round-robin and forwards the winning request combinationally.
- Records each accepted read's master ID in an in-order FIFO, so the slave's later resp/rdata goes to the right master.

---
 rtl/bus_arb_pkg.sv | 18 +
 rtl/bus_arb_idfifo.sv | 66 ++++++
 rtl/bus_arbiter_rr.sv | 155 +++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared constants and helpers for the round-robin bus arbiter.
// Contents: bus field widths, master-ID width function and a reserved
// fake-read-data constant (not yet used).
package bus_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  // Reserved for a future fake response to orphan reads.
  localparam logic [DATA_W-1:0] RDATA_ORPHAN = 32'hDEAD_BEEF;

  // Width needed to hold a master ID; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_arb_idfifo.sv
// In-order FIFO of master IDs for outstanding reads.
// Ports:
//   clk_i, rst_i    clock, asynchronous active-low reset
//   push, din       append din (ignored when full)
//   pop, dout       drop the head (ignored when empty); dout shows the head
//   full, empty     occupancy flags
module bus_arb_idfifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  // Power-of-two depth: pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master to 1-slave arbiter for the req/we/addr/be/wdata/ack/resp/rdata bus.
// Winning request is forwarded combinationally; read master IDs are queued in
// order so slave responses return to the right master.
// Ports:
//   clk_i, rst_i                          clock, asynchronous active-low reset
//   m_req/m_we/m_addr/m_be/m_wdata        packed per-master requests
//   m_ack, m_resp, m_rdata                per-master accept, read valid, data
//   s_req/s_we/s_addr/s_be/s_wdata        request to the slave
//   s_ack, s_resp, s_rdata                slave accept and read response
//   err_o                                 sticky: response with no read pending
// Build option: define BUS_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins) instead of round-robin.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned RD_DEPTH  = 4,
  parameter int unsigned ID_W      = id_width(N_MASTERS)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_MASTERS-1:0]        m_req,
  input  logic [N_MASTERS-1:0]        m_we,
  input  logic [ADDR_W*N_MASTERS-1:0] m_addr,
  input  logic [BE_W*N_MASTERS-1:0]   m_be,
  input  logic [DATA_W*N_MASTERS-1:0] m_wdata,
  output logic [N_MASTERS-1:0]        m_ack,
  output logic [N_MASTERS-1:0]        m_resp,
  output logic [DATA_W*N_MASTERS-1:0] m_rdata,
  output logic                        s_req,
  output logic                        s_we,
  output logic [ADDR_W-1:0]           s_addr,
  output logic [BE_W-1:0]             s_be,
  output logic [DATA_W-1:0]           s_wdata,
  input  logic                        s_ack,
  input  logic                        s_resp,
  input  logic [DATA_W-1:0]           s_rdata,
  output logic                        err_o
);

  logic [N_MASTERS-1:0] elig;
  logic                 grant_valid;
  logic [ID_W-1:0]      grant_idx;
  logic [ID_W-1:0]      scan_start;
  logic                 fifo_full, fifo_empty;
  logic [ID_W-1:0]      fifo_dout;
  logic                 accept, rd_push, rsp_pop, orphan;
  logic                 err_q, err_d;

  // Reads wait while the ID FIFO is full; writes never do. Gating with rst_i
  // drops any in-flight grant the instant reset asserts.
  always_comb begin
    elig = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      elig[k] = rst_i & m_req[k] & (m_we[k] | ~fifo_full);
    end
  end

  // Rotating scan: indices scan_start..N-1 first, then 0..scan_start-1.
  always_comb begin
    int start;
    start       = int'(scan_start);
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (!grant_valid && elig[k] && (k >= start)) begin
        grant_valid = 1'b1;
        grant_idx   = ID_W'(k);
      end
    end
    for (int k = 0; k < N_MASTERS; k++) begin
      if (!grant_valid && elig[k] && (k < start)) begin
        grant_valid = 1'b1;
        grant_idx   = ID_W'(k);
      end
    end
  end

  always_comb begin
    s_req   = grant_valid;
    s_we    = 1'b0;
    s_addr  = '0;
    s_be    = '0;
    s_wdata = '0;
    m_ack   = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (grant_valid && (grant_idx == ID_W'(k))) begin
        s_we     = m_we[k];
        s_addr   = m_addr[k*ADDR_W +: ADDR_W];
        s_be     = m_be[k*BE_W +: BE_W];
        s_wdata  = m_wdata[k*DATA_W +: DATA_W];
        m_ack[k] = s_ack;
      end
    end
  end

  assign accept  = s_req & s_ack;
  assign rd_push = accept & ~s_we;
  assign rsp_pop = s_resp & ~fifo_empty;
  assign orphan  = s_resp & fifo_empty;

  always_comb begin
    m_resp = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      m_resp[k] = rsp_pop & (fifo_dout == ID_W'(k));
    end
  end

  assign m_rdata = {N_MASTERS{s_rdata}};

`ifdef BUS_ARB_FIXED_PRIO_EN
  assign scan_start = '0;
`else
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  // Pointer moves only on accept, so a stalled grant stays put.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (grant_idx == ID_W'(N_MASTERS - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

  assign scan_start = rr_ptr_q;
`endif

  assign err_d = err_q | orphan;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_o = err_q;

  bus_arb_idfifo #(
    .DEPTH(RD_DEPTH),
    .W    (ID_W)
  ) u_idfifo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push (rd_push),
    .din  (grant_idx),
    .pop  (rsp_pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr (2 masters, 4 outstanding reads).
// A queue-based reference model predicts grants and routed responses; a
// monitor compares them against the DUT every cycle.
module tb_bus_arbiter_rr;
  import bus_arb_pkg::*;

  localparam int N     = 2;
  localparam int DEPTH = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    m_req, m_we, m_ack, m_resp;
  logic [32*N-1:0] m_addr, m_wdata, m_rdata;
  logic [4*N-1:0]  m_be;
  logic            s_req, s_we, s_ack, s_resp, err_o;
  logic [31:0]     s_addr, s_wdata, s_rdata;
  logic [3:0]      s_be;

  always #5 clk_i = ~clk_i;

  bus_arbiter_rr #(
    .N_MASTERS(N),
    .RD_DEPTH (DEPTH)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .m_req  (m_req),
    .m_we   (m_we),
    .m_addr (m_addr),
    .m_be   (m_be),
    .m_wdata(m_wdata),
    .m_ack  (m_ack),
    .m_resp (m_resp),
    .m_rdata(m_rdata),
    .s_req  (s_req),
    .s_we   (s_we),
    .s_addr (s_addr),
    .s_be   (s_be),
    .s_wdata(s_wdata),
    .s_ack  (s_ack),
    .s_resp (s_resp),
    .s_rdata(s_rdata),
    .err_o  (err_o)
  );

  typedef struct {
    int          id;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        acked;
  } grant_t;

  typedef struct {
    int          id;
    logic [31:0] rdata;
  } resp_t;

  grant_t gq[$];
  resp_t  rq[$];
  int     checks   = 0;
  int     failures = 0;

  // Reference model state: next-priority master, outstanding read IDs, error.
  int mdl_rr;
  int mdl_ids[$];
  bit mdl_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    bit           found;
    int           g;
    logic [N-1:0] elig;
    grant_t       e;
    resp_t        r;
    found = 0;
    g     = 0;
    for (int k = 0; k < N; k++) elig[k] = m_req[k] && (m_we[k] || mdl_ids.size() < DEPTH);
    for (int i = 0; i < N; i++) begin
      int c;
`ifdef BUS_ARB_FIXED_PRIO_EN
      c = i;
`else
      c = (mdl_rr + i) % N;
`endif
      if (!found && elig[c]) begin
        found = 1;
        g     = c;
      end
    end
    if (found) begin
      e.id    = g;
      e.we    = m_we[g];
      e.addr  = m_addr[g*32 +: 32];
      e.be    = m_be[g*4 +: 4];
      e.wdata = m_wdata[g*32 +: 32];
      e.acked = s_ack;
      gq.push_back(e);
    end
    if (s_resp) begin
      if (mdl_ids.size() > 0) begin
        r.id    = mdl_ids.pop_front();
        r.rdata = s_rdata;
        rq.push_back(r);
      end else begin
        mdl_err = 1;
      end
    end
    if (found && s_ack) begin
      mdl_rr = (g + 1) % N;
      if (!m_we[g]) mdl_ids.push_back(g);
    end
  endtask

  task automatic drive(input logic [N-1:0] req, input logic [N-1:0] we, input logic sack,
                       input logic sresp, input logic [31:0] srdata, input logic [31:0] addr0);
    @(negedge clk_i);
    m_req   = req;
    m_we    = we;
    s_ack   = sack;
    s_resp  = sresp;
    s_rdata = srdata;
    for (int k = 0; k < N; k++) begin
      m_addr[k*32 +: 32]  = {4'(k), 28'($urandom)};
      m_be[k*4 +: 4]      = 4'($urandom);
      m_wdata[k*32 +: 32] = $urandom;
    end
    if (addr0 != 0) m_addr[31:0] = addr0;
    model_step();
  endtask

  task automatic set_idle();
    m_req   = '0;
    m_we    = '0;
    m_addr  = '0;
    m_be    = '0;
    m_wdata = '0;
    s_ack   = 1'b0;
    s_resp  = 1'b0;
    s_rdata = '0;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    set_idle();
    gq.delete();
    rq.delete();
    mdl_ids.delete();
    mdl_rr  = 0;
    mdl_err = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  // Monitor: every cycle, consume whatever the model predicted for it.
  initial begin : monitor
    grant_t       e;
    resp_t        r;
    logic [N-1:0] exp_oh;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_i === 1'b1) begin
        if (s_req) begin
          if (gq.size() == 0) begin
            check("unexpected_s_req", s_req, 1'b0);
          end else begin
            e = gq.pop_front();
            exp_oh = '0;
            if (e.acked) exp_oh[e.id] = 1'b1;
            check("s_we", s_we, e.we);
            check("s_addr", s_addr, e.addr);
            check("s_be", s_be, e.be);
            check("s_wdata", s_wdata, e.wdata);
            check("m_ack", m_ack, exp_oh);
          end
        end else begin
          if (gq.size() != 0) begin
            e = gq.pop_front();
            check("missing_s_req", s_req, 1'b1);
          end
          check("idle_m_ack", m_ack, '0);
          check("idle_s_addr", s_addr, '0);
        end
        if (|m_resp) begin
          if (rq.size() == 0) begin
            check("unexpected_m_resp", m_resp, '0);
          end else begin
            r = rq.pop_front();
            exp_oh = '0;
            exp_oh[r.id] = 1'b1;
            check("m_resp", m_resp, exp_oh);
            check("m_rdata", m_rdata[r.id*32 +: 32], r.rdata);
          end
        end else if (rq.size() != 0) begin
          r = rq.pop_front();
          exp_oh = '0;
          exp_oh[r.id] = 1'b1;
          check("missing_m_resp", m_resp, exp_oh);
        end
      end
    end
  end

  initial begin : stim
    int rr_exp[4];
`ifdef BUS_ARB_FIXED_PRIO_EN
    rr_exp = '{0, 0, 0, 0};
`else
    rr_exp = '{0, 1, 0, 1};
`endif
    rst_i = 1'b0;
    set_idle();

    // Reset state with live requests: nothing may be forwarded or routed.
    m_req  = 2'b11;
    m_we   = 2'b00;
    s_ack  = 1'b1;
    s_resp = 1'b1;
    #12;
    check("rst_m_ack", m_ack, 2'b00);
    check("rst_m_resp", m_resp, 2'b00);
    check("rst_s_req", s_req, 1'b0);
    check("rst_err", err_o, 1'b0);
    do_reset();

    // Round-robin on continuous writes.
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 2'b11, 1'b1, 1'b0, '0, '0);
      #1;
      check("rr_seq", s_addr[31:28], 4'(rr_exp[i]));
    end

    // Stall: grant stays on m0, nothing acked.
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 2'b11, 1'b0, 1'b0, '0, '0);
      #1;
      check("stall_master", s_addr[31:28], 4'h0);
      check("stall_ack", m_ack, 2'b00);
    end

    // Single read with one-cycle response.
    drive(2'b01, 2'b00, 1'b1, 1'b0, '0, 32'h10);
    #1;
    check("rd_addr", s_addr, 32'h10);
    check("rd_ack", m_ack, 2'b01);
    drive(2'b00, 2'b00, 1'b0, 1'b1, 32'hA5A5_A5A5, '0);
    #1;
    check("rd_resp", m_resp, 2'b01);
    check("rd_rdata", m_rdata[31:0], 32'hA5A5_A5A5);

    // Fill the read FIFO: m1, m0, m1, m0.
    drive(2'b10, 2'b00, 1'b1, 1'b0, '0, '0);
    drive(2'b01, 2'b00, 1'b1, 1'b0, '0, '0);
    drive(2'b10, 2'b00, 1'b1, 1'b0, '0, '0);
    drive(2'b01, 2'b00, 1'b1, 1'b0, '0, '0);
    // m1 read blocked while full; m0 write proceeds.
    for (int i = 0; i < 2; i++) begin
      drive(2'b11, 2'b01, 1'b1, 1'b0, '0, '0);
      #1;
      check("full_write_we", s_we, 1'b1);
      check("full_write_ack", m_ack, 2'b01);
    end
    drive(2'b10, 2'b00, 1'b1, 1'b1, $urandom, '0);
    #1;
    check("full_blocked", s_req, 1'b0);
    check("full_resp0", m_resp, 2'b10);
    drive(2'b10, 2'b00, 1'b1, 1'b1, $urandom, '0);
    #1;
    check("unblocked_ack", m_ack, 2'b10);
    check("full_resp1", m_resp, 2'b01);
    drive(2'b00, 2'b00, 1'b0, 1'b1, $urandom, '0);
    drive(2'b00, 2'b00, 1'b0, 1'b1, $urandom, '0);
    drive(2'b00, 2'b00, 1'b0, 1'b1, $urandom, '0);

    // Push and pop in the same cycle at count 2.
    drive(2'b01, 2'b00, 1'b1, 1'b0, '0, '0);
    drive(2'b10, 2'b00, 1'b1, 1'b0, '0, '0);
    drive(2'b01, 2'b00, 1'b1, 1'b1, 32'h1234_5678, '0);
    #1;
    check("pp_ack", m_ack, 2'b01);
    check("pp_resp", m_resp, 2'b01);
    drive(2'b00, 2'b00, 1'b0, 1'b1, $urandom, '0);
    drive(2'b00, 2'b00, 1'b0, 1'b1, $urandom, '0);

    // Randomized traffic, slave responds only with reads outstanding.
    for (int i = 0; i < 400; i++) begin
      logic sr;
      sr = (mdl_ids.size() > 0) && ($urandom_range(0, 2) != 0);
      drive(N'($urandom), N'($urandom), 1'($urandom), sr, $urandom, '0);
    end
    for (int i = 0; i < 8; i++) begin
      if (mdl_ids.size() > 0) drive(2'b00, 2'b00, 1'b0, 1'b1, $urandom, '0);
    end
    #1;
    check("pre_orphan_err", err_o, 1'b0);

    // Orphan response.
    drive(2'b00, 2'b00, 1'b0, 1'b1, 32'hBAD0_BAD0, '0);
    #1;
    check("orphan_resp", m_resp, 2'b00);
    @(posedge clk_i);
    #1;
    check("orphan_err", err_o, 1'b1);

    // Asynchronous reset mid-transfer.
    drive(2'b01, 2'b00, 1'b1, 1'b0, '0, '0);
    drive(2'b01, 2'b00, 1'b1, 1'b0, '0, '0);
    #1;
    check("pre_rst_ack", m_ack, 2'b01);
    #2;
    rst_i  = 1'b0;
    s_resp = 1'b1;
    #1;
    check("async_rst_ack", m_ack, 2'b00);
    check("async_rst_s_req", s_req, 1'b0);
    check("async_rst_resp", m_resp, 2'b00);
    check("async_rst_err", err_o, 1'b0);
    do_reset();

    // Post-reset traffic starts from m0 again.
    drive(2'b11, 2'b11, 1'b1, 1'b0, '0, '0);
    #1;
    check("post_rst_master", s_addr[31:28], 4'h0);
    drive(2'b00, 2'b00, 1'b0, 1'b0, '0, '0);
    @(negedge clk_i);
    #3;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
